// File: rtl/upc_sequencer.sv
// Microprogram sequencer: registered micro-PC with conditional branching,
// a LIFO return stack for CALL/RET, and sticky stack overflow/underflow flags.
module upc_sequencer #(
    parameter int UPC_W = 5,
    parameter int DEPTH = 4,
    parameter int NCOND = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2:0]                 op,
    input  logic [UPC_W-1:0]           target,
    input  logic [$clog2(NCOND)-1:0]   cond_sel,
    input  logic [NCOND-1:0]           cond,
    input  logic                       stall,
    input  logic                       err_clr,
    output logic [UPC_W-1:0]           upc,
    output logic [$clog2(DEPTH):0]     sp,
    output logic                       stack_full,
    output logic                       stack_empty,
    output logic                       ovf_err,
    output logic                       unf_err
);

    localparam int SP_W  = $clog2(DEPTH) + 1;
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [2:0] {
        OP_NEXT    = 3'd0,
        OP_JUMP    = 3'd1,
        OP_JMPT    = 3'd2,
        OP_JMPF    = 3'd3,
        OP_CALL    = 3'd4,
        OP_RET     = 3'd5,
        OP_HOLD    = 3'd6,
        OP_RESTART = 3'd7
    } op_t;

    logic [UPC_W-1:0] stack_mem [DEPTH];

    op_t              op_dec;
    logic [UPC_W-1:0] inc;
    logic             cond_bit;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] pop_idx;
    logic [SP_W-1:0]  sp_plus;
    logic [SP_W-1:0]  sp_minus;

    logic [UPC_W-1:0] next_upc;
    logic [SP_W-1:0]  next_sp;
    logic             push_en;
    logic             ovf_set;
    logic             unf_set;

    assign op_dec      = op_t'(op);
    assign inc         = upc + UPC_W'(1);
    assign cond_bit    = cond[cond_sel];
    assign sp_plus     = sp + SP_W'(1);
    assign sp_minus    = sp - SP_W'(1);
    assign push_idx    = sp[IDX_W-1:0];
    assign pop_idx     = sp_minus[IDX_W-1:0];
    assign stack_full  = (sp == SP_W'(DEPTH));
    assign stack_empty = (sp == '0);

    // Next micro-PC, stack pointer and error-set decisions for the current op.
    always_comb begin
        next_upc = upc;
        next_sp  = sp;
        push_en  = 1'b0;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        unique case (op_dec)
            OP_NEXT: next_upc = inc;
            OP_JUMP: next_upc = target;
            OP_JMPT: next_upc = cond_bit ? target : inc;
            OP_JMPF: next_upc = cond_bit ? inc : target;
            OP_CALL: begin
                if (stack_full) begin
                    next_upc = inc;
                    ovf_set  = 1'b1;
                end else begin
                    next_upc = target;
                    next_sp  = sp_plus;
                    push_en  = 1'b1;
                end
            end
            OP_RET: begin
                if (stack_empty) begin
                    next_upc = '0;
                    unf_set  = 1'b1;
                end else begin
                    next_upc = stack_mem[pop_idx];
                    next_sp  = sp_minus;
                end
            end
            OP_HOLD:    next_upc = upc;
            OP_RESTART: begin
                next_upc = '0;
                next_sp  = '0;
            end
            default:    next_upc = upc;
        endcase
    end

    // Control state; stall freezes everything including err_clr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            upc     <= '0;
            sp      <= '0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else if (!stall) begin
            upc     <= next_upc;
            sp      <= next_sp;
            ovf_err <= ovf_set | (ovf_err & ~err_clr);
            unf_err <= unf_set | (unf_err & ~err_clr);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack_mem[i] <= '0;
            end
        end else if (!stall && push_en) begin
            stack_mem[push_idx] <= inc;
        end
    end

endmodule

// File: tb/tb_upc_sequencer.sv
// Directed self-checking bench for upc_sequencer with default parameters.
module tb_upc_sequencer;

    localparam int UPC_W = 5;
    localparam int DEPTH = 4;
    localparam int NCOND = 4;

    localparam logic [2:0] NEXT = 3'd0, JUMP = 3'd1, JMPT = 3'd2, JMPF = 3'd3,
                           CALL = 3'd4, RET = 3'd5, HOLD = 3'd6, RESTART = 3'd7;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       op;
    logic [UPC_W-1:0] target;
    logic [1:0]       cond_sel;
    logic [NCOND-1:0] cond;
    logic             stall;
    logic             err_clr;
    logic [UPC_W-1:0] upc;
    logic [2:0]       sp;
    logic             stack_full;
    logic             stack_empty;
    logic             ovf_err;
    logic             unf_err;

    int checks = 0;
    int errors = 0;

    upc_sequencer #(.UPC_W(UPC_W), .DEPTH(DEPTH), .NCOND(NCOND)) dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .target      (target),
        .cond_sel    (cond_sel),
        .cond        (cond),
        .stall       (stall),
        .err_clr     (err_clr),
        .upc         (upc),
        .sp          (sp),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .ovf_err     (ovf_err),
        .unf_err     (unf_err)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_state(input string tag, input int e_upc, input int e_sp,
                               input int e_ovf, input int e_unf);
        check_output({tag, ".upc"}, int'(upc), e_upc);
        check_output({tag, ".sp"},  int'(sp),  e_sp);
        check_output({tag, ".ovf"}, int'(ovf_err), e_ovf);
        check_output({tag, ".unf"}, int'(unf_err), e_unf);
    endtask

    // Present one micro-op, then let one rising edge execute it.
    task automatic apply_stimulus(input logic [2:0] o, input int tgt, input logic clr);
        op      = o;
        target  = UPC_W'(tgt);
        err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        op       = NEXT;
        target   = '0;
        cond_sel = '0;
        cond     = '0;
        stall    = 1'b0;
        err_clr  = 1'b0;
        #3;
        check_state("reset", 0, 0, 0, 0);
        check_output("reset.empty", int'(stack_empty), 1);
        check_output("reset.full",  int'(stack_full),  0);
        #4 reset = 1'b1;

        for (int i = 1; i <= 33; i++) begin
            apply_stimulus(NEXT, 0, 1'b0);
            check_output($sformatf("next%0d.upc", i), int'(upc), i % 32);
        end
        check_state("next_end", 1, 0, 0, 0);

        apply_stimulus(JUMP, 3, 1'b0);
        check_state("jump3", 3, 0, 0, 0);
        apply_stimulus(CALL, 10, 1'b0);
        check_state("call10", 10, 1, 0, 0);
        apply_stimulus(RET, 0, 1'b0);
        check_state("ret4", 4, 0, 0, 0);

        apply_stimulus(CALL, 20, 1'b0);
        check_state("nest1", 20, 1, 0, 0);
        apply_stimulus(CALL, 21, 1'b0);
        check_state("nest2", 21, 2, 0, 0);
        apply_stimulus(CALL, 22, 1'b0);
        check_state("nest3", 22, 3, 0, 0);
        apply_stimulus(CALL, 23, 1'b0);
        check_state("nest4", 23, 4, 0, 0);
        check_output("nest4.full", int'(stack_full), 1);
        apply_stimulus(CALL, 24, 1'b0);
        check_state("nest5_ovf", 24, 4, 1, 0);
        apply_stimulus(RET, 0, 1'b0);
        check_state("pop1", 23, 3, 1, 0);
        apply_stimulus(RET, 0, 1'b0);
        check_state("pop2", 22, 2, 1, 0);
        apply_stimulus(RET, 0, 1'b0);
        check_state("pop3", 21, 1, 1, 0);
        apply_stimulus(RET, 0, 1'b0);
        check_state("pop4", 5, 0, 1, 0);
        check_output("pop4.empty", int'(stack_empty), 1);
        apply_stimulus(HOLD, 0, 1'b1);
        check_state("ovf_clr", 5, 0, 0, 0);

        apply_stimulus(RET, 0, 1'b1);
        check_state("unf_setwins", 0, 0, 0, 1);
        apply_stimulus(HOLD, 0, 1'b1);
        check_state("unf_clr", 0, 0, 0, 0);

        cond     = 4'b0100;
        cond_sel = 2'd2;
        apply_stimulus(JMPT, 7, 1'b0);
        check_state("jmpt_taken", 7, 0, 0, 0);
        apply_stimulus(JMPF, 7, 1'b0);
        check_state("jmpf_fall", 8, 0, 0, 0);
        cond = 4'b1011;
        apply_stimulus(JMPT, 7, 1'b0);
        check_state("jmpt_fall", 9, 0, 0, 0);
        apply_stimulus(JMPF, 15, 1'b0);
        check_state("jmpf_taken", 15, 0, 0, 0);
        apply_stimulus(HOLD, 0, 1'b0);
        check_state("hold", 15, 0, 0, 0);

        apply_stimulus(RET, 0, 1'b0);
        check_state("unf_again", 0, 0, 0, 1);
        apply_stimulus(CALL, 9, 1'b0);
        check_state("call9", 9, 1, 0, 1);
        apply_stimulus(RESTART, 0, 1'b0);
        check_state("restart", 0, 0, 0, 1);

        apply_stimulus(CALL, 12, 1'b0);
        check_state("call12", 12, 1, 0, 1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(CALL, 30, 1'b1);
            check_state($sformatf("stall%0d", i), 12, 1, 0, 1);
        end
        reset = 1'b0;
        #2;
        check_state("stall_reset", 0, 0, 0, 0);
        #1 reset = 1'b1;
        stall = 1'b0;
        apply_stimulus(NEXT, 0, 1'b0);
        check_state("post_reset", 1, 0, 0, 0);
        apply_stimulus(RET, 0, 1'b0);
        check_state("post_reset_ret", 0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/upc_sequencer.md
UPC_SEQUENCER -- requirements
Module: upc_sequencer

Interface
REQ-001 Parameter UPC_W, default 5: micro-PC width in bits.
REQ-002 Parameter DEPTH, default 4: return-stack entries, 2..16.
REQ-003 Parameter NCOND, default 4: condition inputs, power of two, at least 2.
REQ-004 The block SHALL have exactly one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-007 op  in  3  micro-op: 0 NEXT, 1 JUMP, 2 JMPT, 3 JMPF, 4 CALL, 5 RET, 6 HOLD, 7 RESTART.
REQ-008 target  in  UPC_W  branch/call destination.
REQ-009 cond_sel  in  log2(NCOND)  selects the tested bit of cond.
REQ-010 cond  in  NCOND  status flags, for example Q0/Q-1 and counter-zero.
REQ-011 stall  in  1  freezes all state when high.
REQ-012 err_clr  in  1  clears the sticky error flags.
REQ-013 upc  out  UPC_W  current micro-PC, registered.
REQ-014 sp  out  log2(DEPTH)+1  current stack occupancy, registered.
REQ-015 stack_full / stack_empty  out  1 each  combinational from sp (sp==DEPTH / sp==0).
REQ-016 ovf_err / unf_err  out  1 each  sticky overflow and underflow flags, registered.

Function
REQ-017 upc, sp and the error flags SHALL change only on a rising clk edge, or on reset.
REQ-018 With stall=1, upc, sp, stack contents and the error flags SHALL hold; op and err_clr are ignored.
REQ-019 The incremented value inc = (upc+1) mod 2^UPC_W; all-ones wraps to 0 with no flag.
REQ-020 NEXT: upc<=inc.
REQ-021 JUMP: upc<=target.
REQ-022 JMPT: upc<=target if cond[cond_sel]=1, else inc; JMPF uses the inverted test.
REQ-023 CALL with sp<DEPTH: push inc to stack[sp], sp<=sp+1, upc<=target.
REQ-024 CALL with sp==DEPTH: no push, sp holds, upc<=inc, ovf_err<=1.
REQ-025 RET with sp>0: upc<=stack[sp-1], sp<=sp-1.
REQ-026 RET with sp==0: upc<=0, sp holds at 0, unf_err<=1.
REQ-027 HOLD: upc holds.
REQ-028 RESTART: upc<=0, sp<=0; error flags are unaffected.
REQ-029 err_clr=1 clears both flags; if a new error occurs in the same cycle, that flag SHALL be set (set wins).
REQ-030 Latency: a micro-op presented in cycle n is reflected on upc after edge n+1, with no bubbles.
REQ-031 Stack storage is LIFO; an entry at index >= sp is don't-care and SHALL NOT be observable on upc.
REQ-032 The cond value is sampled only in the cycle of its JMPT/JMPF; no registering of cond beyond that.

Reset
REQ-033 reset=0 SHALL immediately, without a clock, force upc=0, sp=0, ovf_err=0, unf_err=0 and all stack entries to 0.
REQ-034 Reset asserted mid-CALL/RET or during stall SHALL override everything; no partial push or pop survives.
REQ-035 After reset deasserts, the first rising edge executes op normally.

Verification
REQ-036 Reset, then 33 cycles of NEXT (UPC_W=5) -> upc 1..31, then 0, then 1; no flags.
REQ-037 upc=3, CALL target=10 -> upc=10, sp=1; then RET -> upc=4, sp=0.
REQ-038 Nested CALL x5 with DEPTH=4 -> after the 4th call sp=4 and stack_full=1; the 5th call gives upc=previous+1, ovf_err=1 and sp=4; then RET x4 returns addresses in reverse order.
REQ-039 RET at sp=0 with err_clr=1 in the same cycle -> upc=0, unf_err=1; err_clr alone next cycle -> unf_err=0.
REQ-040 Conditional branch: cond=4'b0100, cond_sel=2, JMPT target=7 -> upc=7; JMPF same inputs from upc=7 -> upc=8.
REQ-041 stall=1 held for 3 cycles with a CALL pending -> upc, sp and flags unchanged; reset pulse mid-stall -> all outputs 0.
